seg_frame_loader: RTL and testbench

SEG_FRAME_LOADER -- requirements
Module: seg_frame_loader

---
 rtl/seg_frame_loader_pkg.sv | 22 ++
 rtl/seg_frame_loader_parser.sv | 100 ++++++++++
 rtl/seg_frame_loader.sv | 83 ++++++++
 tb/tb_seg_frame_loader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_frame_loader_pkg.sv
// Shared definitions for the segment-display frame loader: parser states,
// frame field constants and the frame checksum helper.
package seg_frame_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
    } frame_state_t;

    localparam logic [7:0] SYNC_DEFAULT   = 8'hA5;
    localparam logic [7:0] ADDR_RSVD_MASK = 8'hF8;
    localparam int         NUM_REGS       = 8;
    localparam int         REG_W          = 32;

    // XOR of the address byte and the four data bytes.
    function automatic logic [7:0] frame_chk(input logic [7:0] addr, input logic [31:0] word);
        return addr ^ word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
    endfunction

endpackage

// File: rtl/seg_frame_loader_parser.sv
// Byte-stream frame parser: SYNC, ADDR, D3..D0, CHK. Emits a single-cycle
// commit strobe on the edge the checksum byte is accepted.
module seg_frame_parser
    import seg_frame_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             abort,
    output logic             commit,
    output logic [2:0]       commit_addr,
    output logic [REG_W-1:0] commit_data,
    output logic             frame_ok,
    output logic             frame_err,
    output logic             busy
);

    frame_state_t     state_q, state_d;
    logic [2:0]       addr_q;
    logic [REG_W-1:0] shadow_q;
    logic [1:0]       byte_cnt_q;
    logic             err_d;

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        err_d   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SYNC_BYTE)
                        state_d = ST_ADDR;
                end
                ST_ADDR: begin
                    if ((rx_data & ADDR_RSVD_MASK) != 8'h00) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (byte_cnt_q == 2'd3)
                        state_d = ST_CHK;
                end
                ST_CHK: begin
                    state_d = ST_IDLE;
                    // Accepted addresses have ADDR[7:3] == 0, so the 3-bit copy is exact.
                    if (rx_data == frame_chk({5'b0, addr_q}, shadow_q))
                        commit = 1'b1;
                    else
                        err_d = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            shadow_q   <= '0;
            byte_cnt_q <= '0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_ok  <= commit;
            frame_err <= err_d;
            if (abort) begin
                shadow_q   <= '0;
                byte_cnt_q <= '0;
            end else if (rx_valid) begin
                case (state_q)
                    ST_ADDR: begin
                        addr_q     <= rx_data[2:0];
                        byte_cnt_q <= '0;
                    end
                    ST_DATA: begin
                        shadow_q   <= {shadow_q[REG_W-9:0], rx_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign commit_addr = addr_q;
    assign commit_data = shadow_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: rtl/seg_frame_loader.sv
// UART frame loader for an 8-digit display: parses framed writes into an
// 8-entry register bank and aborts frames that stall between bytes.
module seg_frame_loader
    import seg_frame_loader_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx_valid,
    input  logic [7:0]       i_rx_data,
    output logic [REG_W-1:0] rx_data_reg0,
    output logic [REG_W-1:0] rx_data_reg1,
    output logic [REG_W-1:0] rx_data_reg2,
    output logic [REG_W-1:0] rx_data_reg3,
    output logic [REG_W-1:0] rx_data_reg4,
    output logic [REG_W-1:0] rx_data_reg5,
    output logic [REG_W-1:0] rx_data_reg6,
    output logic [REG_W-1:0] rx_data_reg7,
    output logic             o_frame_ok,
    output logic             o_frame_err,
    output logic             o_busy
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] gap_cnt_q;
    logic             timeout;
    logic             commit;
    logic [2:0]       commit_addr;
    logic [REG_W-1:0] commit_data;
    logic [REG_W-1:0] regs_q [NUM_REGS];

    seg_frame_parser #(
        .SYNC_BYTE(SYNC_BYTE)
    ) u_parser (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .rx_valid   (i_rx_valid),
        .rx_data    (i_rx_data),
        .abort      (timeout),
        .commit     (commit),
        .commit_addr(commit_addr),
        .commit_data(commit_data),
        .frame_ok   (o_frame_ok),
        .frame_err  (o_frame_err),
        .busy       (o_busy)
    );

    // The counter reaches TIMEOUT_CYCLES on the edge that aborts; a byte in that cycle wins.
    assign timeout = o_busy && !i_rx_valid && (gap_cnt_q == CNT_HIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            gap_cnt_q <= '0;
        else if (!o_busy || i_rx_valid || timeout)
            gap_cnt_q <= '0;
        else if (gap_cnt_q != CNT_MAX)
            gap_cnt_q <= gap_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
        end else if (commit) begin
            regs_q[commit_addr] <= commit_data;
        end
    end

    assign rx_data_reg0 = regs_q[0];
    assign rx_data_reg1 = regs_q[1];
    assign rx_data_reg2 = regs_q[2];
    assign rx_data_reg3 = regs_q[3];
    assign rx_data_reg4 = regs_q[4];
    assign rx_data_reg5 = regs_q[5];
    assign rx_data_reg6 = regs_q[6];
    assign rx_data_reg7 = regs_q[7];

endmodule

// File: tb/tb_seg_frame_loader.sv
// Directed bench for seg_frame_loader with hand-computed frames and checksums.
`timescale 1ns/1ps
module tb_seg_frame_loader;

    localparam int TIMEOUT = 16;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic        o_frame_ok, o_frame_err, o_busy;
    logic [31:0] regs_o [8];

    int n_checks = 0;
    int n_fail   = 0;
    int ok_cnt   = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int base_ok, base_err;

    seg_frame_loader #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rx_valid  (i_rx_valid),
        .i_rx_data   (i_rx_data),
        .rx_data_reg0(r0),
        .rx_data_reg1(r1),
        .rx_data_reg2(r2),
        .rx_data_reg3(r3),
        .rx_data_reg4(r4),
        .rx_data_reg5(r5),
        .rx_data_reg6(r6),
        .rx_data_reg7(r7),
        .o_frame_ok  (o_frame_ok),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    assign regs_o[0] = r0;
    assign regs_o[1] = r1;
    assign regs_o[2] = r2;
    assign regs_o[3] = r3;
    assign regs_o[4] = r4;
    assign regs_o[5] = r5;
    assign regs_o[6] = r6;
    assign regs_o[7] = r7;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_frame_ok)  ok_cnt++;
        if (o_frame_err) err_cnt++;
        if (o_frame_ok && o_frame_err) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        step();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [31:0] word, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(addr);
        send_byte(word[31:24]);
        send_byte(word[23:16]);
        send_byte(word[15:8]);
        send_byte(word[7:0]);
        send_byte(chk);
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        repeat (3) step();
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("reset_reg%0d", i), regs_o[i], 32'h0);
        check_eq("reset_busy", {31'b0, o_busy}, 32'h0);
        check_eq("reset_ok", {31'b0, o_frame_ok}, 32'h0);
        check_eq("reset_err", {31'b0, o_frame_err}, 32'h0);
        i_rst_n = 1'b1;
        step();

        // Good frame to reg3; checksum 03^12^34^56^78 = 0B
        base_ok = ok_cnt;
        send_frame(8'h03, 32'h12345678, 8'h0B);
        check_eq("good_reg3", r3, 32'h12345678);
        check_eq("good_ok", {31'b0, o_frame_ok}, 32'h1);
        check_eq("good_err", {31'b0, o_frame_err}, 32'h0);
        check_eq("good_busy", {31'b0, o_busy}, 32'h0);
        for (int i = 0; i < 8; i++)
            if (i != 3) check_eq($sformatf("good_other_reg%0d", i), regs_o[i], 32'h0);
        step();
        check_eq("good_ok_low", {31'b0, o_frame_ok}, 32'h0);
        check_eq("good_ok_pulses", ok_cnt - base_ok, 32'd1);

        // Bad checksums leave reg3 untouched
        send_frame(8'h03, 32'hCAFEF00D, 8'h00);
        check_eq("badchk_err", {31'b0, o_frame_err}, 32'h1);
        check_eq("badchk_ok", {31'b0, o_frame_ok}, 32'h0);
        check_eq("badchk_reg3", r3, 32'h12345678);
        send_frame(8'h03, 32'h12345678, 8'h0F);
        check_eq("badchk0f_err", {31'b0, o_frame_err}, 32'h1);
        check_eq("badchk0f_reg3", r3, 32'h12345678);
        step();

        // Noise in IDLE is silent; reserved address bits abort the frame
        base_err = err_cnt;
        send_byte(8'h00);
        check_eq("noise00_busy", {31'b0, o_busy}, 32'h0);
        send_byte(8'hFF);
        check_eq("noiseff_busy", {31'b0, o_busy}, 32'h0);
        send_byte(8'hA5);
        check_eq("sync_busy", {31'b0, o_busy}, 32'h1);
        send_byte(8'h08);
        check_eq("badaddr_err", {31'b0, o_frame_err}, 32'h1);
        check_eq("badaddr_busy", {31'b0, o_busy}, 32'h0);
        step();
        check_eq("badaddr_err_pulses", err_cnt - base_err, 32'd1);

        // Timeout: error visible 16 cycles after the last byte
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hAA);
        base_err = err_cnt;
        repeat (TIMEOUT - 1) step();
        check_eq("tmo_pre_err", {31'b0, o_frame_err}, 32'h0);
        check_eq("tmo_pre_busy", {31'b0, o_busy}, 32'h1);
        check_eq("tmo_pre_pulses", err_cnt - base_err, 32'd0);
        step();
        check_eq("tmo_err", {31'b0, o_frame_err}, 32'h1);
        check_eq("tmo_busy", {31'b0, o_busy}, 32'h0);
        // 01^DE^AD^BE^EF = 23
        send_frame(8'h01, 32'hDEADBEEF, 8'h23);
        check_eq("after_tmo_ok", {31'b0, o_frame_ok}, 32'h1);
        check_eq("after_tmo_reg1", r1, 32'hDEADBEEF);
        step();

        // Byte arriving on the timeout cycle wins; 05^11^22^33^44 = 41
        base_err = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h05);
        repeat (TIMEOUT - 1) step();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h41);
        check_eq("race_ok", {31'b0, o_frame_ok}, 32'h1);
        check_eq("race_reg5", r5, 32'h11223344);
        step();
        check_eq("race_err_pulses", err_cnt - base_err, 32'd0);

        // Reset after D1 aborts silently
        base_ok  = ok_cnt;
        base_err = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check_eq("midrst_busy_before", {31'b0, o_busy}, 32'h1);
        i_rst_n = 1'b0;
        #1;
        check_eq("midrst_busy_async", {31'b0, o_busy}, 32'h0);
        step();
        step();
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("midrst_reg%0d", i), regs_o[i], 32'h0);
        i_rst_n = 1'b1;
        step();
        check_eq("midrst_busy", {31'b0, o_busy}, 32'h0);
        check_eq("midrst_ok_pulses", ok_cnt - base_ok, 32'd0);
        check_eq("midrst_err_pulses", err_cnt - base_err, 32'd0);

        // Eight back-to-back frames, reg n = n; checksum n^n = 00
        base_ok  = ok_cnt;
        base_err = err_cnt;
        for (int n = 0; n < 8; n++)
            send_frame(8'(n), 32'(n), 8'h00);
        step();
        check_eq("b2b_ok_pulses", ok_cnt - base_ok, 32'd8);
        check_eq("b2b_err_pulses", err_cnt - base_err, 32'd0);
        for (int n = 0; n < 8; n++)
            check_eq($sformatf("b2b_reg%0d", n), regs_o[n], 32'(n));

        check_eq("ok_err_exclusive", both_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
